// File: rtl/dwa_unit_dac_encoder.sv
// Maps the MASH multi-level code onto unit-element DAC enables.
// Ports: clk/rst_n, en strobe, code_in, mode, ptr_clr, ovr_clr -> elem_out, ptr_out, level_out, ovr_flag.
module dwa_unit_dac_encoder #(
  parameter int NUM_ELEM = 7,
  parameter int OFFSET   = 3,
  parameter int PTR_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [3:0]          code_in,
  input  logic                mode,
  input  logic                ptr_clr,
  input  logic                ovr_clr,
  output logic [NUM_ELEM-1:0] elem_out,
  output logic [PTR_W-1:0]    ptr_out,
  output logic [3:0]          level_out,
  output logic                ovr_flag
);

  localparam int SW = ((PTR_W > 4) ? PTR_W : 4) + 1;

  logic [5:0]            w_s;
  logic                  w_neg;
  logic                  w_hi;
  logic                  w_ovr;
  logic [3:0]            w_level;
  logic [NUM_ELEM-1:0]   w_therm;
  logic [2*NUM_ELEM-1:0] w_dbl;
  logic [NUM_ELEM-1:0]   w_rot;
  logic [NUM_ELEM-1:0]   w_elem;
  logic [SW-1:0]         w_sum;
  logic [SW-1:0]         w_nxt;

  logic [NUM_ELEM-1:0]   r_elem;
  logic [PTR_W-1:0]      r_ptr;
  logic [3:0]            r_level;
  logic                  r_ovr;

  // Sign-extended code plus offset; bit 5 is the sign.
  assign w_s   = {{2{code_in[3]}}, code_in} + 6'(OFFSET);
  assign w_neg = w_s[5];
  assign w_hi  = !w_s[5] && (w_s > 6'(NUM_ELEM));
  assign w_ovr = w_neg || w_hi;

  always_comb begin
    w_level = w_s[3:0];
    if (w_neg)
      w_level = 4'd0;
    else if (w_hi)
      w_level = 4'(NUM_ELEM);
  end

  always_comb begin
    w_therm = '0;
    for (int k = 0; k < NUM_ELEM; k++)
      w_therm[k] = (k < int'(w_level));
  end

  // Rotate-left by the pointer: doubling the mask makes the
  // wrap past element NUM_ELEM-1 fall out of a plain shift.
  assign w_dbl  = {w_therm, w_therm} << r_ptr;
  assign w_rot  = w_dbl[2*NUM_ELEM-1:NUM_ELEM];
  assign w_elem = mode ? w_rot : w_therm;

  // p < N and level <= N, so one conditional subtract is a true mod N.
  assign w_sum = SW'(r_ptr) + SW'(w_level);
  assign w_nxt = (w_sum >= SW'(NUM_ELEM)) ? (w_sum - SW'(NUM_ELEM)) : w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_elem  <= '0;
      r_level <= '0;
    end else if (en) begin
      r_elem  <= w_elem;
      r_level <= w_level;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ptr <= '0;
    else if (ptr_clr)
      r_ptr <= '0;
    else if (en && mode)
      r_ptr <= PTR_W'(w_nxt);
  end

  // Set has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ovr <= 1'b0;
    else if (en && w_ovr)
      r_ovr <= 1'b1;
    else if (ovr_clr)
      r_ovr <= 1'b0;
  end

  assign elem_out  = r_elem;
  assign ptr_out   = r_ptr;
  assign level_out = r_level;
  assign ovr_flag  = r_ovr;

endmodule

// File: tb/tb_dwa_unit_dac_encoder.sv
// Directed and randomised checks for dwa_unit_dac_encoder.
// Drives on negedge, samples 1ns after the active edge.
module tb_dwa_unit_dac_encoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] code_in;
  logic       mode;
  logic       ptr_clr;
  logic       ovr_clr;
  logic [6:0] elem_out;
  logic [2:0] ptr_out;
  logic [3:0] level_out;
  logic       ovr_flag;

  int n_vec;
  int n_err;

  dwa_unit_dac_encoder #(
    .NUM_ELEM(7),
    .OFFSET(3),
    .PTR_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .code_in(code_in),
    .mode(mode),
    .ptr_clr(ptr_clr),
    .ovr_clr(ovr_clr),
    .elem_out(elem_out),
    .ptr_out(ptr_out),
    .level_out(level_out),
    .ovr_flag(ovr_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] c,
                      input logic m, input logic pc, input logic oc);
    @(negedge clk);
    en = e; code_in = c; mode = m; ptr_clr = pc; ovr_clr = oc;
    @(posedge clk);
    #1;
    en = 1'b0; ptr_clr = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [6:0] e,
                         input logic [2:0] p, input logic [3:0] l,
                         input logic o);
    chk({tag, ".elem"}, 32'(elem_out), 32'(e));
    chk({tag, ".ptr"}, 32'(ptr_out), 32'(p));
    chk({tag, ".lvl"}, 32'(level_out), 32'(l));
    chk({tag, ".ovr"}, 32'(ovr_flag), 32'(o));
  endtask

  initial begin
    int p;
    int lv;
    int cum;
    int cnt [7];
    int mx;
    int mn;
    logic [6:0] exp_e;
    logic [3:0] c;

    n_vec = 0; n_err = 0;
    rst_n = 1'b0; en = 1'b0; code_in = '0; mode = 1'b1;
    ptr_clr = 1'b0; ovr_clr = 1'b0;
    #12;
    chk_all("reset", 7'd0, 3'd0, 4'd0, 1'b0);
    rst_n = 1'b1;

    // Get a non-zero state, then reset mid-cycle.
    step(1, 4'd0, 1, 0, 0);
    chk_all("pre_rst", 7'b0000111, 3'd3, 4'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 7'd0, 3'd0, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 4'd0, 1, 0, 0);
    chk_all("hold_en0", 7'd0, 3'd0, 4'd0, 1'b0);

    // DWA rotation with level 3.
    step(1, 4'd0, 1, 0, 0);
    chk_all("dwa1", 7'b0000111, 3'd3, 4'd3, 1'b0);
    step(1, 4'd0, 1, 0, 0);
    chk_all("dwa2", 7'b0111000, 3'd6, 4'd3, 1'b0);
    step(1, 4'd0, 1, 0, 0);
    chk_all("dwa3_wrap", 7'b1000011, 3'd2, 4'd3, 1'b0);

    // Extremes.
    step(1, 4'd4, 1, 0, 0);
    chk_all("full", 7'b1111111, 3'd2, 4'd7, 1'b0);
    step(1, 4'b1101, 1, 0, 0);
    chk_all("empty", 7'd0, 3'd2, 4'd0, 1'b0);

    // Saturation and sticky flag.
    step(1, 4'b0101, 1, 0, 0);
    chk_all("sat_hi", 7'b1111111, 3'd2, 4'd7, 1'b1);
    step(0, 4'd0, 1, 0, 1);
    chk_all("ovr_clr", 7'b1111111, 3'd2, 4'd7, 1'b0);
    step(1, 4'b1100, 1, 0, 0);
    chk_all("sat_lo", 7'd0, 3'd2, 4'd0, 1'b1);
    step(1, 4'b0101, 1, 0, 1);
    chk_all("set_wins", 7'b1111111, 3'd2, 4'd7, 1'b1);
    step(0, 4'd0, 1, 0, 1);
    chk("ovr_clr2", 32'(ovr_flag), 32'd0);

    // Thermometer and pointer clear.
    step(1, 4'd0, 1, 0, 0);
    chk_all("to_p5", 7'b0011100, 3'd5, 4'd3, 1'b0);
    step(1, 4'd1, 0, 0, 0);
    chk_all("therm", 7'b0001111, 3'd5, 4'd4, 1'b0);
    step(1, 4'd0, 1, 1, 0);
    chk_all("clr_en", 7'b1100001, 3'd0, 4'd3, 1'b0);
    step(1, 4'd0, 1, 0, 0);
    chk_all("post_clr", 7'b0000111, 3'd3, 4'd3, 1'b0);
    step(0, 4'd0, 1, 1, 0);
    chk_all("clr_noen", 7'b0000111, 3'd0, 4'd3, 1'b0);

    // Random in-range codes in DWA mode from pointer 0.
    p = 0; cum = 0;
    for (int k = 0; k < 7; k++) cnt[k] = 0;
    for (int i = 0; i < 10000; i++) begin
      lv = int'($urandom_range(0, 7));
      c = 4'(lv - 3);
      step(1, c, 1, 0, 0);
      exp_e = '0;
      for (int j = 0; j < lv; j++) exp_e[(p + j) % 7] = 1'b1;
      p = (p + lv) % 7;
      chk("rnd.pop", 32'($countones(elem_out)), 32'(level_out));
      if (elem_out !== exp_e || ptr_out !== 3'(p) || level_out !== 4'(lv))
        chk("rnd.state", {elem_out, ptr_out, level_out},
            {exp_e, 3'(p), 4'(lv)});
      for (int k = 0; k < 7; k++) cnt[k] += int'(elem_out[k]);
      cum += lv;
      if (cum % 7 == 0) begin
        mx = cnt[0]; mn = cnt[0];
        for (int k = 1; k < 7; k++) begin
          if (cnt[k] > mx) mx = cnt[k];
          if (cnt[k] < mn) mn = cnt[k];
        end
        chk("rnd.balance", 32'(mx - mn <= 1), 32'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dwa_unit_dac_encoder.md
Name: dwa_unit_dac_encoder

Overview:
Downstream stage of the 1-1-1 MASH modulator. It converts the modulator's 4-bit signed multi-level code (nominal range -3..+4) into on/off controls for the unit elements of a unit-element DAC. In normal mode it applies data-weighted averaging (DWA) element rotation, which first-order shapes element-mismatch error. It also has a static thermometer mode for debug/characterisation, and it saturates out-of-range codes and reports them with a sticky flag.

Parameters:
NUM_ELEM, 7, number of unit DAC elements; max level = NUM_ELEM (2..15 supported)
OFFSET, 3, added to signed code_in to form the unsigned level
PTR_W, 3, rotation pointer width; must satisfy 2**PTR_W >= NUM_ELEM

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
en  in  1  sample strobe; code_in consumed on cycles where en=1
code_in  in  4  signed two's-complement modulator code
mode  in  1  1 = DWA rotation, 0 = static thermometer
ptr_clr  in  1  synchronous rotation-pointer clear
ovr_clr  in  1  synchronous clear of ovr_flag
elem_out  out  NUM_ELEM  registered unit-element enables; bit i drives element i
ptr_out  out  PTR_W  current rotation pointer (registered)
level_out  out  4  registered level applied to elem_out (0..NUM_ELEM)
ovr_flag  out  1  sticky out-of-range indicator

Behaviour:
- Reset (rst_n is asynchronous, active-low; clock is clk):
  - elem_out = 0, ptr_out = 0, level_out = 0, ovr_flag = 0.
- Level computation (combinational, 6-bit signed):
  - s = sign_extend(code_in) + OFFSET.
  - s < 0 → level = 0 and overflow event.
  - s > NUM_ELEM → level = NUM_ELEM and overflow event.
  - Otherwise level = s.
- Latency:
  - elem_out, level_out and ptr_out update at the clk edge on which en=1 is sampled. This is one cycle of latency from code_in.
  - en=0: all outputs hold; no pointer movement; no overflow detection.
- DWA mode (mode=1), with current pointer p:
  - elem_out bit k = 1 for k = (p+j) mod NUM_ELEM, j = 0..level-1; all other bits = 0.
  - Next pointer = (p + level) mod NUM_ELEM. The modulo is true modulo NUM_ELEM, not 2**PTR_W, including wrap past element NUM_ELEM-1.
  - level = 0: all elements off, pointer unchanged.
  - level = NUM_ELEM: all elements on, pointer unchanged.
- Thermometer mode (mode=0):
  - elem_out bits 0..level-1 set.
  - Pointer holds its value; it is not reset.
  - A mode change takes effect on the next en sample; no pipeline flush.
- ptr_clr (effective only in the cycle it is high):
  - Pointer becomes 0 at the next edge, regardless of en. It overrides any advance.
  - If en=1 in the same cycle, that sample's elem_out is computed with the pre-clear pointer.
- ovr_flag:
  - Set at the edge of any en sample with an overflow event.
  - Cleared by ovr_clr.
  - Set and clear in the same cycle → set wins.
- Reset mid-operation: all state returns immediately to reset values; the first sample after release rotates from element 0.
- Invariant: popcount(elem_out) == level_out at all times.

Test Plan:
- Reset/hold: assert rst_n=0 mid-stream with elem_out≠0 → all outputs 0 immediately. Release, en=0 for 5 cycles → outputs stay 0.
- DWA rotation: mode=1, en=1, code_in=0 (level 3) for 3 samples:
  - sample 1 → elem_out=7'b0000111, ptr 3
  - sample 2 → elem_out=7'b0111000, ptr 6
  - sample 3 → elem_out=7'b1000011 (wrap), ptr 2
- Extremes: from ptr 2, code_in=+4 (level 7) → elem_out=7'b1111111, ptr stays 2. Then code_in=-3 (level 0) → elem_out=0, ptr 2, ovr_flag stays 0.
- Saturation:
  - code_in=4'b0101 (+5) → level_out=7, ovr_flag=1.
  - ovr_clr with en=0 → ovr_flag=0.
  - code_in=4'b1100 (-4) → level_out=0, ovr_flag=1.
  - Then ovr_clr=1 and overflowing sample in the same cycle → ovr_flag remains 1.
- Thermometer/ptr_clr:
  - mode=0, code_in=+1 (level 4) → elem_out=7'b0001111, ptr unchanged (e.g. 5).
  - ptr_clr=1 with en=1 → that sample uses old ptr, ptr_out=0 afterwards.
- Random: 10k random in-range codes in DWA mode → popcount(elem_out)==level_out every sample. Each element's on-count differs from every other element's by ≤1 at every sample where cumulative level is a multiple of NUM_ELEM.
